dmac_slave: RTL and testbench

Bus-slave register front end of the DMA controller, directly upstream of the DMAC master engine. It decodes CPU register reads and writes and stages descriptors (source address, destination address, size), which it pushes into an 8-entry descriptor FIFO. The master pops that FIFO; this block generates the master's `op_start`/`op_clear` pulses and `opmode`. It also latches the master's `op_done` into an interrupt/status bit.

---
 rtl/dmac_slave_if.sv | 29 ++
 rtl/dmac_slave.sv | 165 ++++++++++++++++
 tb/tb_dmac_slave.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_slave_if.sv
// CPU-side register bus of the DMA controller slave.
//   S_sel     : slave select for this access
//   S_wr      : 1 = write, 0 = read (qualified by S_sel)
//   S_address : word register offset
//   S_din     : write data
//   S_dout    : registered read data (0 in cycles with no read)
interface dmac_slave_if;
    logic        S_sel;
    logic        S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S_dout;

    modport master (
        output S_sel,
        output S_wr,
        output S_address,
        output S_din,
        input  S_dout
    );

    modport slave (
        input  S_sel,
        input  S_wr,
        input  S_address,
        input  S_din,
        output S_dout
    );
endinterface

// File: rtl/dmac_slave.sv
// Register front end of the DMA controller. Decodes CPU register accesses, stages
// descriptors and queues them in a descriptor FIFO that the master engine pops.
//   clk, reset_n          : clock, asynchronous active-low reset
//   bus                   : CPU register bus (dmac_slave_if.slave)
//   op_done               : level from master, transfer list finished
//   rd_en                 : pop request from master
//   op_start, op_clear    : one-cycle pulses to master
//   opmode                : {30'b0, mode}; bit0 src increment, bit1 dst increment
//   sc_addr, ds_addr,
//   data_size             : registered head entry, loaded on each successful pop
//   data_count            : entries currently held (0..FIFO_DEPTH)
//   interrupt             : done_flag & int_en
module dmac_slave #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    dmac_slave_if.slave  bus,
    input  logic         op_done,
    input  logic         rd_en,
    output logic         op_start,
    output logic         op_clear,
    output logic [31:0]  opmode,
    output logic [31:0]  sc_addr,
    output logic [31:0]  ds_addr,
    output logic [31:0]  data_size,
    output logic [3:0]   data_count,
    output logic         interrupt
);
    logic [31:0] src_q, dst_q, size_q;
    logic        int_en_q;
    logic [1:0]  mode_q;
    logic        busy_q, done_flag_q;
    logic        start_q, clear_q;
    logic [31:0] dout_q;
    logic [31:0] sc_q, ds_q, sz_q;
    logic [2:0]  wr_ptr_q, rd_ptr_q;
    logic [3:0]  count_q, count_d;

    logic [31:0] mem_src [FIFO_DEPTH];
    logic [31:0] mem_dst [FIFO_DEPTH];
    logic [31:0] mem_size[FIFO_DEPTH];

    logic        wr_en, rd_req;
    logic        full, empty;
    logic        start_req, clear_req, push_req;
    logic        do_push, do_pop;
    logic [31:0] rdata;

    assign wr_en  = bus.S_sel & bus.S_wr;
    assign rd_req = bus.S_sel & ~bus.S_wr;
    assign full   = (count_q == 4'(FIFO_DEPTH));
    assign empty  = (count_q == 4'd0);

    assign start_req = wr_en && (bus.S_address == 8'h00) && bus.S_din[0] && !busy_q && !empty;
    assign clear_req = wr_en && (bus.S_address == 8'h08) && bus.S_din[0];
    assign push_req  = wr_en && (bus.S_address == 8'h06) && bus.S_din[0];

    // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign do_push = push_req && !full;
    assign do_pop  = rd_en && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        if (rd_req) begin
            case (bus.S_address)
                8'h01:   rdata = {31'd0, done_flag_q};
                8'h02:   rdata = {31'd0, int_en_q};
                8'h03:   rdata = src_q;
                8'h04:   rdata = dst_q;
                8'h05:   rdata = size_q;
                8'h07:   rdata = {30'd0, mode_q};
                8'h09:   rdata = {28'd0, count_q};
                8'h0A:   rdata = {29'd0, full, empty, busy_q};
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            size_q      <= 32'd0;
            int_en_q    <= 1'b0;
            mode_q      <= 2'd0;
            busy_q      <= 1'b0;
            done_flag_q <= 1'b0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            dout_q      <= 32'd0;
            sc_q        <= 32'd0;
            ds_q        <= 32'd0;
            sz_q        <= 32'd0;
            wr_ptr_q    <= 3'd0;
            rd_ptr_q    <= 3'd0;
            count_q     <= 4'd0;
        end else begin
            start_q <= start_req;
            clear_q <= clear_req;
            dout_q  <= rdata;
            count_q <= count_d;

            if (wr_en) begin
                case (bus.S_address)
                    8'h02:   int_en_q <= bus.S_din[0];
                    8'h03:   src_q    <= bus.S_din;
                    8'h04:   dst_q    <= bus.S_din;
                    8'h05:   size_q   <= bus.S_din;
                    8'h07:   mode_q   <= bus.S_din[1:0];
                    default: ;
                endcase
            end

            // CLEAR beats a simultaneous op_done; a held op_done re-sets done next cycle.
            if (clear_req) begin
                done_flag_q <= 1'b0;
                busy_q      <= 1'b0;
            end else if (op_done) begin
                done_flag_q <= 1'b1;
                busy_q      <= 1'b0;
            end else if (start_req) begin
                busy_q <= 1'b1;
            end

            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 3'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 3'd1;
                sc_q     <= mem_src[rd_ptr_q];
                ds_q     <= mem_dst[rd_ptr_q];
                sz_q     <= mem_size[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_src[wr_ptr_q]  <= src_q;
            mem_dst[wr_ptr_q]  <= dst_q;
            mem_size[wr_ptr_q] <= size_q;
        end
    end

    assign bus.S_dout = dout_q;
    assign op_start   = start_q;
    assign op_clear   = clear_q;
    assign opmode     = {30'd0, mode_q};
    assign sc_addr    = sc_q;
    assign ds_addr    = ds_q;
    assign data_size  = sz_q;
    assign data_count = count_q;
    assign interrupt  = done_flag_q & int_en_q;
endmodule

// File: tb/tb_dmac_slave.sv
module tb_dmac_slave;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_done = 1'b0;
    logic        rd_en = 1'b0;
    logic        op_start, op_clear, interrupt;
    logic [31:0] opmode, sc_addr, ds_addr, data_size;
    logic [3:0]  data_count;

    dmac_slave_if bus ();

    dmac_slave #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .op_done    (op_done),
        .rd_en      (rd_en),
        .op_start   (op_start),
        .op_clear   (op_clear),
        .opmode     (opmode),
        .sc_addr    (sc_addr),
        .ds_addr    (ds_addr),
        .data_size  (data_size),
        .data_count (data_count),
        .interrupt  (interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] z;
    } desc_t;

    typedef struct {
        logic [31:0] dout;
        logic        start;
        logic        clear;
        logic [31:0] opmode;
        logic [31:0] sc;
        logic [31:0] ds;
        logic [31:0] sz;
        logic [3:0]  cnt;
        logic        intr;
    } exp_t;

    exp_t  exp_q[$];
    desc_t m_fifo[$];

    // Reference model state
    logic [31:0] m_src, m_dst, m_size, m_sc, m_ds, m_sz;
    logic [1:0]  m_mode;
    logic        m_int_en, m_busy, m_done;
    logic        op_done_lvl = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_src = 0; m_dst = 0; m_size = 0; m_sc = 0; m_ds = 0; m_sz = 0;
        m_mode = 0; m_int_en = 0; m_busy = 0; m_done = 0;
        m_fifo.delete();
    endtask

    // Drive one bus cycle and record the outputs expected after the next rising edge.
    task automatic cycle(input logic sel, input logic wr, input logic [7:0] addr,
                         input logic [31:0] din, input logic rde);
        exp_t  e;
        desc_t dsc;
        int    cnt;
        logic  w, start, clear, push;
        @(negedge clk);
        bus.S_sel = sel; bus.S_wr = wr; bus.S_address = addr; bus.S_din = din;
        rd_en = rde;
        op_done = op_done_lvl;

        cnt = m_fifo.size();
        e.dout = 0;
        if (sel && !wr) begin
            case (addr)
                8'h01: e.dout = {31'd0, m_done};
                8'h02: e.dout = {31'd0, m_int_en};
                8'h03: e.dout = m_src;
                8'h04: e.dout = m_dst;
                8'h05: e.dout = m_size;
                8'h07: e.dout = {30'd0, m_mode};
                8'h09: e.dout = cnt;
                8'h0A: e.dout = {29'd0, cnt == 8, cnt == 0, m_busy};
                default: e.dout = 0;
            endcase
        end
        w     = sel && wr;
        start = w && addr == 8'h00 && din[0] && !m_busy && cnt != 0;
        clear = w && addr == 8'h08 && din[0];
        push  = w && addr == 8'h06 && din[0];

        if (rde && cnt > 0) begin
            dsc = m_fifo.pop_front();
            m_sc = dsc.s; m_ds = dsc.d; m_sz = dsc.z;
        end
        if (push && cnt < 8) begin
            dsc.s = m_src; dsc.d = m_dst; dsc.z = m_size;
            m_fifo.push_back(dsc);
        end
        if (w) begin
            case (addr)
                8'h02: m_int_en = din[0];
                8'h03: m_src = din;
                8'h04: m_dst = din;
                8'h05: m_size = din;
                8'h07: m_mode = din[1:0];
                default: ;
            endcase
        end
        if (clear) begin
            m_done = 0; m_busy = 0;
        end else if (op_done_lvl) begin
            m_done = 1; m_busy = 0;
        end else if (start) begin
            m_busy = 1;
        end

        e.start = start; e.clear = clear; e.opmode = {30'd0, m_mode};
        e.sc = m_sc; e.ds = m_ds; e.sz = m_sz;
        e.cnt = 4'(m_fifo.size());
        e.intr = m_done && m_int_en;
        exp_q.push_back(e);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, d, 1'b0);
    endtask
    task automatic rd_reg(input logic [7:0] a);
        cycle(1'b1, 1'b0, a, 32'd0, 1'b0);
    endtask
    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 32'd0, 1'b0);
    endtask
    task automatic pop();
        cycle(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
    endtask
    task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
        wr_reg(8'h03, s); wr_reg(8'h04, d); wr_reg(8'h05, z); wr_reg(8'h06, 32'd1);
    endtask
    // Wait for the edge that samples the last driven cycle, then look at outputs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        idle();
        op_done_lvl = 0;
        @(negedge clk);
        bus.S_sel = 0; rd_en = 0; op_done = 0;
        // The idle edge just sampled changes nothing in the model state.
        exp_q.delete();
        reset_n = 0;
        model_reset();
        #1;
        chk("rst_count", 32'(data_count), 0);
        chk("rst_start", 32'(op_start), 0);
        chk("rst_clear", 32'(op_clear), 0);
        chk("rst_dout", bus.S_dout, 0);
        chk("rst_opmode", opmode, 0);
        chk("rst_sc", sc_addr, 0);
        chk("rst_intr", 32'(interrupt), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    // Scoreboard monitor: compares every sampled edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("S_dout", bus.S_dout, e.dout);
                chk("op_start", 32'(op_start), 32'(e.start));
                chk("op_clear", 32'(op_clear), 32'(e.clear));
                chk("opmode", opmode, e.opmode);
                chk("sc_addr", sc_addr, e.sc);
                chk("ds_addr", ds_addr, e.ds);
                chk("data_size", data_size, e.sz);
                chk("data_count", 32'(data_count), 32'(e.cnt));
                chk("interrupt", 32'(interrupt), 32'(e.intr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        bus.S_sel = 0; bus.S_wr = 0; bus.S_address = 0; bus.S_din = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("por_count", 32'(data_count), 0);
        reset_n = 1;

        rd_reg(8'h0A);
        settle();
        chk("status_after_reset", bus.S_dout, 32'h2);

        // Push/pop order
        push_desc(32'h10, 32'h80, 32'h4);
        push_desc(32'h20, 32'h90, 32'h2);
        settle();
        chk("two_pushed", 32'(data_count), 2);
        pop();
        settle();
        chk("pop1_src", sc_addr, 32'h10);
        chk("pop1_cnt", 32'(data_count), 1);
        pop();
        settle();
        chk("pop2_src", sc_addr, 32'h20);
        chk("pop2_dst", ds_addr, 32'h90);
        chk("pop2_size", data_size, 32'h2);
        chk("pop2_cnt", 32'(data_count), 0);

        // Full and empty
        for (int i = 0; i < 9; i++) push_desc(32'h100 + i, 32'h200 + i, i + 1);
        rd_reg(8'h0A);
        settle();
        chk("full_status", bus.S_dout, 32'h4);
        chk("full_cnt", 32'(data_count), 8);
        for (int i = 0; i < 9; i++) pop();
        settle();
        chk("empty_cnt", 32'(data_count), 0);
        chk("hold_8th", sc_addr, 32'h107);

        // Wrap-around and simultaneous push/pop
        for (int i = 0; i < 6; i++) push_desc(32'h300 + i, 32'h400 + i, 32'h10 + i);
        for (int i = 0; i < 6; i++) pop();
        for (int i = 0; i < 5; i++) push_desc(32'h500 + i, 32'h600 + i, 32'h20 + i);
        pop(); pop();
        settle();
        chk("wrap_cnt3", 32'(data_count), 3);
        cycle(1'b1, 1'b1, 8'h06, 32'd1, 1'b1);
        settle();
        chk("pushpop_cnt", 32'(data_count), 3);
        for (int i = 0; i < 3; i++) pop();
        cycle(1'b1, 1'b1, 8'h06, 32'd1, 1'b1);
        settle();
        chk("pushpop_empty", 32'(data_count), 1);
        pop();

        // Start gating
        wr_reg(8'h00, 32'd1);
        settle();
        chk("start_empty", 32'(op_start), 0);
        push_desc(32'h11, 32'h22, 32'h33);
        wr_reg(8'h00, 32'd1);
        settle();
        chk("start_pulse", 32'(op_start), 1);
        rd_reg(8'h0A);
        settle();
        chk("start_one_cycle", 32'(op_start), 0);
        chk("busy", bus.S_dout, 32'h1);
        wr_reg(8'h00, 32'd1);
        settle();
        chk("start_busy", 32'(op_start), 0);

        // Done and interrupt
        wr_reg(8'h02, 32'd1);
        wr_reg(8'h07, 32'hFFFF_FFFF);
        settle();
        chk("opmode3", opmode, 32'h3);
        op_done_lvl = 1;
        idle();
        op_done_lvl = 0;
        settle();
        chk("intr_set", 32'(interrupt), 1);
        rd_reg(8'h01);
        settle();
        chk("int_reg", bus.S_dout, 32'h1);
        wr_reg(8'h08, 32'd1);
        settle();
        chk("clear_pulse", 32'(op_clear), 1);
        chk("intr_clr", 32'(interrupt), 0);
        rd_reg(8'h0A);
        // CLEAR and op_done together: clear wins, done re-sets next cycle
        op_done_lvl = 1;
        wr_reg(8'h08, 32'd1);
        idle();
        op_done_lvl = 0;
        idle();

        // Reset mid-operation
        push_desc(32'hA, 32'hB, 32'hC);
        wr_reg(8'h00, 32'd1);
        do_reset();
        rd_reg(8'h0A);
        settle();
        chk("status_mid_reset", bus.S_dout, 32'h2);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) op_done_lvl = ~op_done_lvl;
            a = 8'($urandom_range(0, 11));
            d = $urandom;
            if (a == 8'h00 || a == 8'h06 || a == 8'h08) d[0] = ($urandom_range(0, 3) != 0);
            if (a == 8'h08 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d,
                  $urandom_range(0, 3) == 0);
        end
        op_done_lvl = 0;
        idle();
        settle();
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
